// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU port and a single-port Ram.
// Latency: read hit returns data the cycle after accept; read miss returns it 3 cycles after accept (1-cycle Ram); write occupies 1 cycle.
// Backpressure: cpu_ready is low while a write or miss is in flight; a request presented then is ignored and must be held.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> request; cpu_ready = controller idle
//   cpu_rdata/cpu_rvalid              <- read response, cpu_rvalid is a one-cycle pulse
//   mem_addr/mem_wdata/mem_we/mem_re  -> Ram address, data_in, write_enable, read_enable
//   mem_rdata/mem_valid               <- Ram data_out, valid_out
//   hit_count/miss_count              <- read hit/miss counters, present only when STATS_EN is defined
//
// Optional feature macro: STATS_EN (saturating 16-bit read hit/miss counters).

module cache_controller #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 4,
    parameter int INDEX_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic              cpu_ready,
    output logic [WIDTH-1:0]  cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_valid
`ifdef STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int TAG_W     = ADDR_W - INDEX_W;
    localparam int NUM_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        MISS_REQ  = 2'd2,
        MISS_WAIT = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Line storage. Only the valid bits need reset; data and tags are
    // meaningless until their valid bit is set.
    logic [WIDTH-1:0]     line_dat [NUM_LINES];
    logic [TAG_W-1:0]     line_tag [NUM_LINES];
    logic [NUM_LINES-1:0] line_vld;

    // Captured request. The read/write direction is not stored separately:
    // WRITE vs MISS_* already encodes it for the whole transaction.
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;

    logic [INDEX_W-1:0] cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               cpu_hit;
    logic               req_hit;
    logic               accept;
    logic               fill;

    assign cpu_idx = cpu_addr[INDEX_W-1:0];
    assign cpu_tag = cpu_addr[ADDR_W-1:INDEX_W];
    assign req_idx = req_addr[INDEX_W-1:0];
    assign req_tag = req_addr[ADDR_W-1:INDEX_W];

    // cpu_hit looks up the incoming address (read-hit service in IDLE);
    // req_hit looks up the captured address (line update during WRITE).
    assign cpu_hit = line_vld[cpu_idx] && (line_tag[cpu_idx] == cpu_tag);
    assign req_hit = line_vld[req_idx] && (line_tag[req_idx] == req_tag);

    assign accept = cpu_req && cpu_ready;
    assign fill   = (state == MISS_WAIT) && mem_valid;

    // The Ram sees the captured request; mem_we/mem_re qualify it.
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and Ram strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cpu_ready = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    if (cpu_we) begin
                        state_nxt = WRITE;
                    end else if (!cpu_hit) begin
                        state_nxt = MISS_REQ;
                    end
                    // read hit: served from the line array, stay in IDLE
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                state_nxt = IDLE;
            end
            MISS_REQ: begin
                mem_re    = 1'b1;
                state_nxt = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, valid bits and read response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            line_vld   <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            if (accept) begin
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
                if (!cpu_we && cpu_hit) begin
                    cpu_rdata  <= line_dat[cpu_idx];
                    cpu_rvalid <= 1'b1;
                end
            end
            if (fill) begin
                line_vld[req_idx] <= 1'b1;
                cpu_rdata         <= mem_rdata;
                cpu_rvalid        <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line data and tags
    // A miss fill replaces whatever the index held; write-through means
    // the evicted line is already in the Ram. A write miss leaves the
    // array untouched (no allocate).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fill) begin
            line_dat[req_idx] <= mem_rdata;
            line_tag[req_idx] <= req_tag;
        end else if ((state == WRITE) && req_hit) begin
            line_dat[req_idx] <= req_wdata;
        end
    end

`ifdef STATS_EN
    // ------------------------------------------------------------------
    // Saturating read hit/miss counters, counted at accept
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept && !cpu_we) begin
            if (cpu_hit) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else begin
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_valid = 1'b0;
`ifdef STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    always #5 clk = ~clk;

    cache_controller dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid)
`ifdef STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Ram model: data and valid one cycle after read_enable.
    logic [31:0] ram [16] = '{32'h0, 32'h11111111, 32'h22222222, 32'h0,
                              32'h0, 32'h0,        32'h0,        32'h0,
                              32'h0, 32'h0,        32'h0,        32'h0,
                              32'h0, 32'h0,        32'h0,        32'h0};

    always @(posedge clk) begin
        mem_valid <= mem_re;
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a read at a negedge; lat counts negedges after the accept edge
    // until cpu_rvalid is seen (bounded). re1/ra1 are the Ram strobes in
    // the first cycle after accept; rv_after is cpu_rvalid one cycle later.
    task automatic do_read(input logic [3:0] a, output logic [31:0] d, output int lat,
                           output logic re1, output logic [3:0] ra1, output logic rv_after);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        lat = 0; re1 = 1'b0; ra1 = 4'h0; d = 32'h0;
        @(posedge clk);
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cpu_req = 1'b0;
                re1 = mem_re;
                ra1 = mem_addr;
            end
            if (cpu_rvalid) break;
        end
        d = cpu_rdata;
        @(negedge clk);
        rv_after = cpu_rvalid;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] v,
                            output logic we1, output logic [3:0] wa1, output logic [31:0] wd1,
                            output logic rdy1, output logic re1, output logic we2, output logic rdy2);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = v;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        we1  = mem_we;
        wa1  = mem_addr;
        wd1  = mem_wdata;
        rdy1 = cpu_ready;
        re1  = mem_re;
        @(negedge clk);
        we2  = mem_we;
        rdy2 = cpu_ready;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    logic [31:0] d;
    int          lat;
    logic        re1, rv_after, we1, rdy1, we2, rdy2, wre1, rv_seen;
    logic [3:0]  ra1, wa1;
    logic [31:0] wd1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 32'h0;
        #1;
        chk("rst_ready",  cpu_ready,  1'b1);
        chk("rst_rvalid", cpu_rvalid, 1'b0);
        chk("rst_rdata",  cpu_rdata,  32'h0);
        chk("rst_mem_we", mem_we,     1'b0);
        chk("rst_mem_re", mem_re,     1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: cold read miss, Ram returns 0
        do_read(4'h5, d, lat, re1, ra1, rv_after);
        chk("t1_lat",   lat, 3);
        chk("t1_data",  d, 32'h0);
        chk("t1_re",    re1, 1'b1);
        chk("t1_raddr", ra1, 4'h5);
        chk("t1_pulse", rv_after, 1'b0);

        pulse_reset();
`ifdef STATS_EN
        chk("st_rst_hit",  hit_count,  16'd0);
        chk("st_rst_miss", miss_count, 16'd0);
`endif

        // 2: write miss (no allocate), read miss fill, read hit
        do_write(4'h5, 32'hDEADBEEF, we1, wa1, wd1, rdy1, wre1, we2, rdy2);
        chk("t2_we",     we1, 1'b1);
        chk("t2_waddr",  wa1, 4'h5);
        chk("t2_wdata",  wd1, 32'hDEADBEEF);
        chk("t2_busy",   rdy1, 1'b0);
        chk("t2_no_re",  wre1, 1'b0);
        chk("t2_we_off", we2, 1'b0);
        chk("t2_ready",  rdy2, 1'b1);
        do_read(4'h5, d, lat, re1, ra1, rv_after);
        chk("t2_miss_lat",  lat, 3);
        chk("t2_miss_data", d, 32'hDEADBEEF);
        chk("t2_miss_re",   re1, 1'b1);
        do_read(4'h5, d, lat, re1, ra1, rv_after);
        chk("t2_hit_lat",   lat, 1);
        chk("t2_hit_data",  d, 32'hDEADBEEF);
        chk("t2_hit_no_re", re1, 1'b0);
        chk("t2_hit_pulse", rv_after, 1'b0);
`ifdef STATS_EN
        chk("st_hit",  hit_count,  16'd1);
        chk("st_miss", miss_count, 16'd1);
`endif

        // 3: write hit updates the line
        do_write(4'h5, 32'h12345678, we1, wa1, wd1, rdy1, wre1, we2, rdy2);
        chk("t3_we",    we1, 1'b1);
        chk("t3_wdata", wd1, 32'h12345678);
        do_read(4'h5, d, lat, re1, ra1, rv_after);
        chk("t3_lat",   lat, 1);
        chk("t3_data",  d, 32'h12345678);
        chk("t3_no_re", re1, 1'b0);

        // 4: conflict eviction on index 1
        do_read(4'h1, d, lat, re1, ra1, rv_after);
        chk("t4_fill_lat",  lat, 3);
        chk("t4_fill_data", d, 32'h11111111);
        do_read(4'h5, d, lat, re1, ra1, rv_after);
        chk("t4_evict_lat",  lat, 3);
        chk("t4_evict_data", d, 32'h12345678);
        do_read(4'h1, d, lat, re1, ra1, rv_after);
        chk("t4_remiss_lat",  lat, 3);
        chk("t4_remiss_re",   re1, 1'b1);
        chk("t4_remiss_addr", ra1, 4'h1);
        chk("t4_remiss_data", d, 32'h11111111);

        // back-to-back hits with the request held high
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rv1",   cpu_rvalid, 1'b1);
        chk("b2b_data1", cpu_rdata, 32'h11111111);
        chk("b2b_rdy",   cpu_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        chk("b2b_rv2",   cpu_rvalid, 1'b1);
        chk("b2b_no_re", mem_re, 1'b0);
        @(negedge clk);
        chk("b2b_rv_off", cpu_rvalid, 1'b0);

        // write miss to index 1 (tag 2) leaves the resident line alone
        do_write(4'h9, 32'h99999999, we1, wa1, wd1, rdy1, wre1, we2, rdy2);
        chk("na_waddr", wa1, 4'h9);
        do_read(4'h1, d, lat, re1, ra1, rv_after);
        chk("na_hit_lat",  lat, 1);
        chk("na_hit_data", d, 32'h11111111);
        do_read(4'h9, d, lat, re1, ra1, rv_after);
        chk("na_miss_lat",  lat, 3);
        chk("na_miss_data", d, 32'h99999999);

        // 5: reset during MISS_WAIT
        do_read(4'h2, d, lat, re1, ra1, rv_after);
        chk("t5_fill_data", d, 32'h22222222);
        do_read(4'h2, d, lat, re1, ra1, rv_after);
        chk("t5_hit_lat", lat, 1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        chk("t5_re", mem_re, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_ready",  cpu_ready, 1'b1);
        chk("t5_rvalid", cpu_rvalid, 1'b0);
        chk("t5_re_off", mem_re, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        rv_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rv_seen = rv_seen | cpu_rvalid;
        end
        chk("t5_no_rvalid", rv_seen, 1'b0);
`ifdef STATS_EN
        chk("st_mid_hit",  hit_count,  16'd0);
        chk("st_mid_miss", miss_count, 16'd0);
`endif
        do_read(4'h2, d, lat, re1, ra1, rv_after);
        chk("t5_post_lat",  lat, 3);
        chk("t5_post_re",   re1, 1'b1);
        chk("t5_post_data", d, 32'h22222222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
